// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3/storetype encodings, FSM state and fault classifier for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] ST_BYTE = 3'b000;
  localparam logic [2:0] ST_HALF = 3'b001;
  localparam logic [2:0] ST_WORD = 3'b010;

  typedef enum logic {IDLE, RMW_WR} lsu_state_e;

  // Misalignment or unsupported funct3; stores share the load encodings for SB/SH/SW
  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic f;
    f = 1'b0;
    if (we) begin
      if (f3[2] || (f3[1] && f3[0])) f = 1'b1;
      else if (f3 == F3_LH)          f = off[0];
      else if (f3 == F3_LW)          f = (off != 2'b00);
    end else begin
      case (f3)
        F3_LB, F3_LBU: f = 1'b0;
        F3_LH, F3_LHU: f = off[0];
        F3_LW:         f = (off != 2'b00);
        default:       f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - picks the addressed byte/half of a memory word and extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'b0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'b0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte-addressed load/store to word memory, RMW for offset sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 11,
  parameter int P_DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_we,
  input  logic [2:0]              i_funct3,
  input  logic [31:0]             i_addr,
  input  logic [P_DATA_WIDTH-1:0] i_wdata,
  output logic                    o_rsp_valid,
  output logic [P_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                    o_rsp_fault,
  output logic                    o_mem_we,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [2:0]              o_mem_storetype,
  output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

  lsu_state_e              state;
  logic [P_ADDR_WIDTH-1:0] word_addr;
  logic [P_ADDR_WIDTH-1:0] rmw_addr;
  logic [P_DATA_WIDTH-1:0] rmw_data;
  logic [P_DATA_WIDTH-1:0] merged;
  logic [P_DATA_WIDTH-1:0] load_data;
  logic [1:0]              off;
  logic                    accept;
  logic                    fault;
  logic                    rmw_st;
  logic                    direct_st;
  logic                    mem_we_raw;
  logic                    unused_addr_hi;

  // Upper address bits are dropped so accesses wrap modulo the memory size
  assign word_addr      = i_addr[P_ADDR_WIDTH+1:2];
  assign off            = i_addr[1:0];
  assign unused_addr_hi = ^i_addr[31:P_ADDR_WIDTH+2];

  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign fault       = is_fault(i_req_we, i_funct3, off);
  assign direct_st   = i_req_we && !fault && (off == 2'b00);
  assign rmw_st      = i_req_we && !fault && (off != 2'b00);

  lsu_load_align u_load_align (
    .word   (i_mem_rdata),
    .off    (off),
    .funct3 (i_funct3),
    .data   (load_data)
  );

  always_comb begin
    merged = i_mem_rdata;
    case (off)
      2'd1:    merged[15:8] = i_wdata[7:0];
      2'd2: begin
        if (i_funct3 == F3_LH) merged[31:16] = i_wdata[15:0];
        else                   merged[23:16] = i_wdata[7:0];
      end
      2'd3:    merged[31:24] = i_wdata[7:0];
      default: merged = i_mem_rdata;
    endcase
  end

  always_comb begin
    if (state == RMW_WR) begin
      mem_we_raw      = 1'b1;
      o_mem_addr      = rmw_addr;
      o_mem_storetype = ST_WORD;
      o_mem_wdata     = rmw_data;
    end else begin
      mem_we_raw      = accept && direct_st;
      o_mem_addr      = word_addr;
      o_mem_storetype = i_funct3;
      o_mem_wdata     = i_wdata;
    end
  end

  // Gating with reset keeps a half-finished RMW from reaching memory
  assign o_mem_we = mem_we_raw && i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_fault <= 1'b0;
      rmw_addr    <= '0;
      rmw_data    <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              o_rsp_valid <= 1'b1;
              o_rsp_fault <= 1'b1;
            end else if (rmw_st) begin
              rmw_addr <= word_addr;
              rmw_data <= merged;
              state    <= RMW_WR;
            end else begin
              o_rsp_valid <= 1'b1;
              if (!i_req_we) o_rsp_rdata <= load_data;
            end
          end
        end
        RMW_WR: begin
          o_rsp_valid <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a word memory model
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW = 11;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_we = 1'b0;
  logic [2:0]    i_funct3 = 3'b000;
  logic [31:0]   i_addr = '0;
  logic [31:0]   i_wdata = '0;
  logic          o_rsp_valid;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_fault;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [2:0]    o_mem_storetype;
  logic [31:0]   o_mem_wdata;
  logic [31:0]   i_mem_rdata;

  load_store_unit #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(32)) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_we        (i_req_we),
    .i_funct3        (i_funct3),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_rdata     (o_rsp_rdata),
    .o_rsp_fault     (o_rsp_fault),
    .o_mem_we        (o_mem_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_storetype (o_mem_storetype),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_rdata     (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          init_mem = 1'b1;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  assign i_mem_rdata = mem[o_mem_addr];

  always @(posedge i_clk) begin
    if (init_mem) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (o_mem_we) begin
      case (o_mem_storetype)
        3'b000:  mem[o_mem_addr][7:0]  <= o_mem_wdata[7:0];
        3'b001:  mem[o_mem_addr][15:0] <= o_mem_wdata[15:0];
        default: mem[o_mem_addr]       <= o_mem_wdata;
      endcase
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   we_cnt = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_mem_we) we_cnt++;
    if (o_rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", o_rsp_rdata, mon_e.rdata);
        check("rsp_fault", {31'b0, o_rsp_fault}, {31'b0, mon_e.fault});
        check("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_fault, input int lat, input bit push);
    int waitc;
    waitc = 0;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_funct3    = f3;
    i_addr      = addr;
    i_wdata     = wdata;
    @(negedge i_clk);
    while (!o_req_ready && waitc < 20) begin
      waitc++;
      @(negedge i_clk);
    end
    if (!o_req_ready) check("ready_timeout", 32'd0, 32'd1);
    else if (push) sb.push_back('{rdata: exp_rdata, fault: exp_fault, cyc: cyc + lat});
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] d);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge i_clk);
    #1 bd_we = 1'b0;
  endtask

  int          we0;
  logic [31:0] saved;

  initial begin
    // A store is presented during reset: memory must not see a write
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_funct3    = F3_LW;
    i_addr      = 32'h10;
    i_wdata     = 32'hFFFF_FFFF;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    check("rst_rsp_fault", {31'b0, o_rsp_fault}, 32'd0);
    check("rst_mem_we", {31'b0, o_mem_we}, 32'd0);
    check("rst_ready", {31'b0, o_req_ready}, 32'd1);
    i_req_valid = 1'b0;
    init_mem = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    do_req(1'b1, F3_LW,  32'h10, 32'h8000_00F0, 32'h0,         1'b0, 1, 1'b1);
    do_req(1'b0, F3_LB,  32'h10, 32'h0,         32'hFFFF_FFF0, 1'b0, 1, 1'b1);
    do_req(1'b0, F3_LBU, 32'h10, 32'h0,         32'h0000_00F0, 1'b0, 1, 1'b1);
    do_req(1'b0, F3_LH,  32'h12, 32'h0,         32'hFFFF_8000, 1'b0, 1, 1'b1);
    drain();
    check("mem_w4", mem[4], 32'h8000_00F0);

    bd_write(11'd8, 32'h1122_3344);
    do_req(1'b1, F3_LB, 32'h21, 32'h0000_00AB, 32'h0, 1'b0, 2, 1'b1);
    @(negedge i_clk);
    check("rmw_ready_low", {31'b0, o_req_ready}, 32'd0);
    check("rmw_mem_we", {31'b0, o_mem_we}, 32'd1);
    check("rmw_mem_addr", {21'b0, o_mem_addr}, 32'd8);
    check("rmw_storetype", {29'b0, o_mem_storetype}, {29'b0, ST_WORD});
    check("rmw_wdata", o_mem_wdata, 32'h1122_AB44);
    drain();
    check("mem_w8_sb", mem[8], 32'h1122_AB44);

    do_req(1'b1, F3_LH,  32'h22, 32'h0000_BEEF, 32'h0,         1'b0, 2, 1'b1);
    do_req(1'b0, F3_LW,  32'h20, 32'h0,         32'hBEEF_AB44, 1'b0, 1, 1'b1);
    do_req(1'b0, F3_LHU, 32'h22, 32'h0,         32'h0000_BEEF, 1'b0, 1, 1'b1);
    do_req(1'b0, F3_LB,  32'h23, 32'h0,         32'hFFFF_FFBE, 1'b0, 1, 1'b1);
    drain();
    check("mem_w8_sh", mem[8], 32'hBEEF_AB44);

    we0 = we_cnt;
    saved = mem[12];
    do_req(1'b1, F3_LW,  32'h31, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1);
    do_req(1'b0, F3_LH,  32'h23, 32'h0,         32'h0, 1'b1, 1, 1'b1);
    do_req(1'b0, 3'b011, 32'h30, 32'h0,         32'h0, 1'b1, 1, 1'b1);
    do_req(1'b1, 3'b011, 32'h30, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1);
    do_req(1'b1, F3_LH,  32'h31, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1);
    do_req(1'b0, 3'b110, 32'h30, 32'h0,         32'h0, 1'b1, 1, 1'b1);
    do_req(1'b1, F3_LBU, 32'h30, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1);
    drain();
    check("fault_no_write", we_cnt, we0);
    check("fault_mem_w12", mem[12], saved);

    do_req(1'b1, F3_LW, 32'h40, 32'hCAFE_F00D, 32'h0,         1'b0, 1, 1'b1);
    do_req(1'b0, F3_LW, 32'h40, 32'h0,         32'hCAFE_F00D, 1'b0, 1, 1'b1);

    do_req(1'b1, F3_LW, 32'h0000_2004, 32'h1234_5678, 32'h0,         1'b0, 1, 1'b1);
    do_req(1'b0, F3_LW, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0, 1, 1'b1);
    drain();
    check("wrap_mem_w1", mem[1], 32'h1234_5678);

    // Reset lands in RMW_WR: the merged word must never be written
    saved = mem[20];
    do_req(1'b1, F3_LB, 32'h51, 32'h0000_0077, 32'h0, 1'b0, 2, 1'b0);
    #1 i_rst_n = 1'b0;
    #1;
    check("rstrmw_mem_we", {31'b0, o_mem_we}, 32'd0);
    check("rstrmw_ready", {31'b0, o_req_ready}, 32'd1);
    check("rstrmw_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    check("rstrmw_rsp_rdata", o_rsp_rdata, 32'd0);
    check("rstrmw_rsp_fault", {31'b0, o_rsp_fault}, 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rstrmw_mem_w20", mem[20], saved);
    check("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit placed directly upstream of the word-addressed data memory. Converts RV32I byte-addressed load/store requests into word accesses.
- Loads: extracts and sign/zero-extends the addressed byte, halfword or word.
- Stores: sub-word stores at non-zero byte offsets are performed as two-cycle read-modify-write.
- Misaligned and illegal accesses are trapped before any memory access.

Parameters:
- P_ADDR_WIDTH, 11, word-address width of the data memory.
- P_DATA_WIDTH, 32, data word width (only 32 supported).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
- i_req_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and faults.
- o_rsp_fault  out  1  misaligned or illegal funct3; valid with o_rsp_valid.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  P_ADDR_WIDTH  word address.
- o_mem_storetype  out  3  000 = byte lane [7:0], 001 = half lane [15:0], other = full word.
- o_mem_wdata  out  32  memory write data.
- i_mem_rdata  in  32  combinational memory read data.

Behaviour:
- Reset (async, i_rst_n low): state IDLE; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_fault=0, RMW registers cleared; o_mem_we forced 0 while reset is asserted.
- Address split: word address = i_addr[P_ADDR_WIDTH+1:2]; off = i_addr[1:0]. Upper address bits are ignored, so the address wraps modulo memory size.
- States: IDLE, RMW_WR.
- o_req_ready = 1 only in IDLE.
- IDLE:
  - o_mem_addr = word address of i_addr (combinational).
  - o_mem_we = 0 unless a direct store is accepted.
- Fault classification:
  - Fault: LH/LHU/SH with off[0]=1; LW/SW with off≠0; funct3 011/110/111 on a load; funct3 ≥ 011 on a store.
  - On fault: no memory write. Next cycle o_rsp_valid=1, o_rsp_fault=1, o_rsp_rdata=0.
- Load, accepted in cycle N:
  - Select lane by off: LB/LBU take byte off; LH/LHU take half off[1]; LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Result is registered; o_rsp_valid pulses in cycle N+1. Latency 1.
- Direct store (SW off=0, SH off=0, SB off=0):
  - In cycle N: o_mem_we=1, o_mem_storetype=010/001/000, o_mem_wdata=i_wdata.
  - o_rsp_valid pulses in N+1. Stay in IDLE.
- RMW store (SB off∈{1,2,3}, SH off=2):
  - Cycle N: memory read only. Register the word address and the merged word (i_mem_rdata with the byte/half lane replaced by i_wdata[7:0]/[15:0]). Go to RMW_WR.
  - Cycle N+1: o_mem_we=1, o_mem_storetype=010, o_mem_addr and o_mem_wdata from the registers, o_req_ready=0. Return to IDLE.
  - Cycle N+2: o_rsp_valid pulse.
- Throughput:
  - Back-to-back accepted requests are allowed in IDLE.
  - A response pulse may coincide with the next accept.
  - No response back-pressure.
- Read-after-write: a load accepted the cycle after a write observes the written data, because memory writes on the clock edge.
- Reset during RMW_WR: the write is abandoned, memory is unchanged, and no response is issued.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - Storetype constants ST_BYTE=000, ST_HALF=001, ST_WORD=010.
  - State enum {IDLE, RMW_WR}.
- One combinational sub-module, lsu_load_align: inputs word, off, funct3; output extended 32-bit data.

Test Plan:
- Reset, then write 0x8000_00F0 via SW to addr 0x10; LB at 0x10 -> rdata 0xFFFF_FFF0; LBU at 0x10 -> 0x0000_00F0; LH at 0x12 -> 0xFFFF_8000. Each response arrives 1 cycle after accept.
- With word 0x1122_3344 at 0x20: SB 0xAB at 0x21 -> ready low 1 cycle, memory word 0x1122_AB44, rsp_valid at N+2. SH 0xBEEF at 0x22 -> word 0xBEEF_AB44.
- SW at 0x31, LH at 0x23, load with funct3 011 -> rsp_fault=1, rdata=0, o_mem_we never asserted, memory unchanged.
- Back-to-back SW 0xCAFE_F00D at 0x40 then LW at 0x40 -> LW returns 0xCAFE_F00D.
- Address 0x0000_2004 with P_ADDR_WIDTH=11 -> aliases to word 1 (wrap).
- Assert i_rst_n low in RMW_WR of SB at 0x51 -> target word unchanged, no rsp_valid, all outputs at reset values.
